// File: rtl/wrselb_pkg.sv
// Shared types for the read-modify-write store unit.
// Holds the FSM encoding, store size codes and the alignment check.
package wrselb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_X = 2'd3;

    // True for any request that must be rejected with err.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = lo[0];
            SIZE_W:  bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/wrselb_merge.sv
// Lane merge for sub-word stores; write-side mirror of rdselb.
// Ports: old (RAM word), data (right-aligned store data), size, lane -> new_word.
module wrselb_merge
    import wrselb_pkg::*;
(
    input  logic [31:0] old,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] new_word
);

    always_comb begin
        new_word = old;
        case (size)
            SIZE_B: begin
                case (lane)
                    2'd0: new_word[7:0]   = data[7:0];
                    2'd1: new_word[15:8]  = data[7:0];
                    2'd2: new_word[23:16] = data[7:0];
                    default: new_word[31:24] = data[7:0];
                endcase
            end
            SIZE_H: begin
                if (lane[1]) new_word[31:16] = data[15:0];
                else         new_word[15:0]  = data[15:0];
            end
            SIZE_W:  new_word = data;
            default: new_word = old;
        endcase
    end

endmodule

// File: rtl/wrselb_rmw.sv
// Byte/half/word store unit for a RAM without byte enables (read-modify-write).
// Ports: req_* handshake in, mem_rd_* / mem_wr_* RAM side, done and err pulses.
module wrselb_rmw
    import wrselb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic [31:0]           req_data,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [31:0]           mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [31:0]           mem_wr_data,
    output logic                  done,
    output logic                  err
);

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [1:0]            size_q;
    logic [31:0]           data_q;
    logic [31:0]           wdata_q;
    logic                  err_q;
    logic [31:0]           merged;
    logic                  accept;
    logic                  bad;

    assign accept = req_valid && (state == S_IDLE);
    assign bad    = misaligned(req_size, req_addr[1:0]);

    wrselb_merge u_merge (
        .old      (mem_rd_data),
        .data     (data_q),
        .size     (size_q),
        .lane     (addr_q[1:0]),
        .new_word (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept && !bad)
                    state_nx = (req_size == SIZE_W) ? S_WRITE : S_READ;
            end
            S_READ:  state_nx = S_WAIT;
            S_WAIT:  state_nx = S_WRITE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE:  req_ready = 1'b1;
            S_READ:  mem_rd_en = 1'b1;
            S_WRITE: begin
                mem_wr_en = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    // Word stores bypass the read and load the write register directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            size_q  <= '0;
            data_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && bad;
            if (accept) begin
                addr_q <= req_addr;
                size_q <= req_size;
                data_q <= req_data;
                if (req_size == SIZE_W) wdata_q <= req_data;
            end
            if (state == S_WAIT) wdata_q <= merged;
        end
    end

    assign mem_rd_addr = addr_q[ADDR_WIDTH+1:2];
    assign mem_wr_addr = addr_q[ADDR_WIDTH+1:2];
    assign mem_wr_data = wdata_q;
    assign err         = err_q;

endmodule

// File: doc/wrselb_rmw.md
# wrselb_rmw

Byte/halfword/word store unit for a 32-bit word-addressed synchronous RAM with no byte enables. It accepts a store request and merges the sub-word data into the addressed lanes with a read-modify-write sequence. It is the write-side counterpart of `rdselb`, which handles the load-side lane selection and sign extension. Lane numbering matches `rdselb`: lane 0 is bits 7:0, little-endian.

## Interface
- `ADDR_WIDTH`, default 10: word-address width of the RAM.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  1  store request valid.
- `req_ready`  out  1  unit idle and able to accept a request.
- `req_addr`  in  ADDR_WIDTH+2  byte address.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_data`  in  32  store data, right-aligned: byte in 7:0, half in 15:0.
- `mem_rd_en`  out  1  RAM read strobe.
- `mem_rd_addr`  out  ADDR_WIDTH  RAM read word address.
- `mem_rd_data`  in  32  RAM read data, valid the cycle after `mem_rd_en`.
- `mem_wr_en`  out  1  RAM write strobe.
- `mem_wr_addr`  out  ADDR_WIDTH  RAM write word address.
- `mem_wr_data`  out  32  RAM write data.
- `done`  out  1  one-cycle pulse, coincident with `mem_wr_en`.
- `err`  out  1  one-cycle pulse, misaligned or illegal request.

## Operation
- **Handshake:** a request is accepted when `req_valid && req_ready`. On acceptance, addr, size and data are latched.
- **Request lines:** ignored whenever `req_ready=0`.
- **States:** IDLE, READ, WAIT, WRITE.
  - IDLE: `req_ready=1`.
    - Accepted word request goes to WRITE.
    - Accepted byte or half request goes to READ.
    - Misaligned or illegal request: stay in IDLE and register `err=1` for one cycle.
      - Misaligned half: `addr[0]=1`.
      - Misaligned word: `addr[1:0]!=0`.
      - Illegal: `size=3`.
  - READ: `mem_rd_en=1`, `mem_rd_addr=addr[ADDR_WIDTH+1:2]`. Next state WAIT.
  - WAIT: merge `mem_rd_data` with the latched data into the write register. Next state WRITE.
  - WRITE: `mem_wr_en=1`, `done=1`, `mem_wr_addr=addr[ADDR_WIDTH+1:2]`. Next state IDLE.
- **Merge rules:**
  - Byte: lane `addr[1:0]` takes `req_data[7:0]`; other lanes keep the read data.
  - Half: if `addr[1]=0`, bits 15:0 are written; if `addr[1]=1`, bits 31:16. The other half keeps the read data.
  - Word: `req_data` is written unchanged; no read is issued.
- **Address outputs:** hold the latched word address outside active cycles. Their value is don't-care when the strobes are low.
- **Reset:** asserting `rst_n` low in any state forces IDLE immediately.
  - `mem_rd_en`, `mem_wr_en`, `done`, `err` go to 0.
  - `req_ready` goes to 1.
  - Data and address registers go to 0.
  - A store interrupted by reset is dropped; no partial write is issued.

## Timing
- Handshake at cycle T.
- Byte/half: READ at T+1, WAIT at T+2, WRITE/`done` at T+3. Next acceptance possible at T+4.
- Word: WRITE/`done` at T+1. Next acceptance at T+2.
- `err` is high at T+1 only. `req_ready` stays 1 throughout, so a new request can be accepted at T+1.
- **No forwarding:** a RAM write at cycle N must be visible to a read at N+1 or later. This is standard synchronous RAM behaviour. Because requests are only accepted in IDLE, back-to-back RMW to the same word is hazard-free.
- All outputs are decoded from registered state or registers; there are no combinational paths from inputs to outputs except none. `req_ready` is a pure function of state.

## Structure
- **Package `wrselb_pkg`:**
  - State encoding.
  - Size codes `SIZE_B`, `SIZE_H`, `SIZE_W`.
  - Function `misaligned(size, addr[1:0])`.
- **Sub-module `wrselb_merge`:** purely combinational; inputs `old[31:0]`, `data[31:0]`, `size`, `lane[1:0]`; output `new[31:0]`. It is instantiated in the WAIT datapath and is the mirror of `rdselb`.
- **Top:** FSM plus request and write-data registers.

## Test plan
All scenarios start from RAM word 5 = 0x788EFD0C unless noted; byte address 0x14 corresponds to word 5.
- **Byte store:** 0xAA at byte addr 0x15 -> `mem_rd_en` at T+1, `mem_wr_en`/`done` at T+3, word 5 = 0x788EAA0C.
- **Half store:** 0x1234 at byte addr 0x16 -> word 5 = 0x1234FD0C. Also 0x5678 at 0x14 -> 0x1234**5678** (upper half preserved).
- **Word store:** 0xDEADBEEF at 0x14 -> no `mem_rd_en`, `mem_wr_en` at T+1, word 5 = 0xDEADBEEF.
- **Errors:** half at 0x15, word at 0x16, and `size=3` -> `err` pulse at T+1, no RAM strobes, word 5 unchanged, `req_ready` stays 1.
- **Back-to-back bytes:** 0x11, 0x22, 0x33, 0x44 at 0x14..0x17 with `req_valid` held -> final word 5 = 0x44332211, four `done` pulses 4 cycles apart.
- **Reset mid-operation:** `rst_n` low during WAIT -> all strobes 0 immediately, no write, word 5 unchanged. The next byte request after release completes normally.
